// File: rtl/mult_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mult_pkg;

  localparam int MULT_OP_W   = 4;
  localparam int MULT_PROD_W = 8;

  // Transaction life cycle of the shared multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } mult_sh_state_t;

  // Width-safe round-robin successor of a requester index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_req);
    rr_next = (idx + 1) % num_req;
  endfunction

endpackage

// File: rtl/multiplier.sv
// Unsigned combinational 4x4 multiplier with an exact 8-bit product.
module multiplier
  import mult_pkg::*;
(
  input  logic [MULT_OP_W-1:0]   a,
  input  logic [MULT_OP_W-1:0]   b,
  output logic [MULT_PROD_W-1:0] product
);

  // Zero-extend both operands so the product is computed at full width.
  assign product = {{(MULT_PROD_W-MULT_OP_W){1'b0}}, a} *
                   {{(MULT_PROD_W-MULT_OP_W){1'b0}}, b};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request
// at or after ptr, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  // Scan ptr, ptr+1, ... and keep the first hit only.
  always_comb begin
    int unsigned      idx;
    logic [ID_W-1:0]  idx_w;
    grant_oh  = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(ptr) + k) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (!any_req && req[idx_w]) begin
        any_req          = 1'b1;
        grant_idx        = idx_w;
        grant_oh[idx_w]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier between NUM_REQ requesters.
// Operands are captured on grant, multiplied in CALC and the product is
// registered into a response held until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. req_ready depends only on
// req_valid, rr_ptr and state, never on the requester's operands; a
// requester must hold req_valid and its operands until it sees req_ready.
// resp_valid, resp_product and resp_id stay stable until resp_ready is
// high; resp_ready while resp_valid is low has no effect.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [MULT_OP_W*NUM_REQ-1:0]   req_a,
  input  logic [MULT_OP_W*NUM_REQ-1:0]   req_b,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [MULT_PROD_W-1:0]         resp_product,
  output logic [ID_W-1:0]                resp_id,
  output logic                           busy
);

  mult_sh_state_t          state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [MULT_OP_W-1:0]    op_a_q, op_a_d;
  logic [MULT_OP_W-1:0]    op_b_q, op_b_d;
  logic [ID_W-1:0]         op_id_q, op_id_d;
  logic [MULT_PROD_W-1:0]  resp_product_q, resp_product_d;
  logic [ID_W-1:0]         resp_id_q, resp_id_d;

  logic [NUM_REQ-1:0]      grant_oh;
  logic [ID_W-1:0]         grant_idx;
  logic                    any_req;
  logic [MULT_OP_W-1:0]    sel_a;
  logic [MULT_OP_W-1:0]    sel_b;
  logic [MULT_PROD_W-1:0]  mult_product;
  logic                    accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // The only multiplier instance; it always sees the registered operands.
  multiplier u_multiplier (
    .a       (op_a_q),
    .b       (op_b_q),
    .product (mult_product)
  );

  // Operand slices of the currently granted requester.
  always_comb begin
    sel_a = req_a[int'(grant_idx)*MULT_OP_W +: MULT_OP_W];
    sel_b = req_b[int'(grant_idx)*MULT_OP_W +: MULT_OP_W];
  end

  // Request-side ready is offered only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst) begin
      req_ready = grant_oh;
    end
  end

  assign accept       = (state_q == IDLE) && any_req;
  assign resp_valid   = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign resp_product = resp_product_q;
  assign resp_id      = resp_id_q;

  // Next-state and datapath capture for the IDLE -> CALC -> RESP cycle.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_id_d        = op_id_q;
    resp_product_d = resp_product_q;
    resp_id_d      = resp_id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          op_id_d  = grant_idx;
          // Pointer moves past the winner so it gets lowest priority next.
          rr_ptr_d = ID_W'(rr_next(int'(grant_idx), NUM_REQ));
          state_d  = CALC;
        end
      end
      CALC: begin
        resp_product_d = mult_product;
        resp_id_d      = op_id_q;
        state_d        = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_id_q        <= '0;
      resp_product_q <= '0;
      resp_id_q      <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_id_q        <= op_id_d;
      resp_product_q <= resp_product_d;
      resp_id_q      <= resp_id_d;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with hand-computed expectations.
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_product;
  logic [1:0]  resp_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mult_share_arbiter #(
    .NUM_REQ (4),
    .ID_W    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .resp_id      (resp_id),
    .busy         (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic set_op(input int idx, input logic [3:0] a, input logic [3:0] b);
    req_a[4*idx +: 4] = a;
    req_b[4*idx +: 4] = b;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req_valid = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated request with resp_ready held high.
  task automatic do_single(input string tag, input int idx, input logic [3:0] a,
                           input logic [3:0] b, input logic [7:0] exp_prod);
    @(negedge clk);
    set_op(idx, a, b);
    req_valid  = 4'b0001 << idx;
    resp_ready = 1'b1;
    #1;
    check({tag, "_ready"}, req_ready, 4'b0001 << idx);
    @(posedge clk); #1;
    check({tag, "_calc_busy"}, busy, 1);
    check({tag, "_calc_ready"}, req_ready, 0);
    check({tag, "_calc_valid"}, resp_valid, 0);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_prod"}, resp_product, exp_prod);
    check({tag, "_id"}, resp_id, idx);
    @(posedge clk); #1;
    check({tag, "_done_valid"}, resp_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    logic [7:0] rr_prod [4];
    rr_prod[0] = 8'd2; rr_prod[1] = 8'd6; rr_prod[2] = 8'd12; rr_prod[3] = 8'd20;

    rst        = 1'b1;
    req_valid  = 4'b0000;
    req_a      = 16'h0000;
    req_b      = 16'h0000;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_product", resp_product, 0);
    check("rst_id", resp_id, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // 1 and 2: single requests, boundaries of the operand range
    do_single("t1_3x5", 0, 4'd3, 4'd5, 8'd15);
    do_single("t2_15x15", 2, 4'd15, 4'd15, 8'd225);
    do_single("t2_0x9", 2, 4'd0, 4'd9, 8'd0);
    do_single("t2_9x0", 1, 4'd9, 4'd0, 8'd0);

    // 3: all requesters valid, rotation 0,1,2,3,0 with one op every 3 cycles
    pulse_reset();
    for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'(i + 2));
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_grant", req_ready, 4'b0001 << (k % 4));
      @(posedge clk); #1;
      check("t3_calc_busy", busy, 1);
      @(posedge clk); #1;
      check("t3_resp_valid", resp_valid, 1);
      check("t3_id", resp_id, k % 4);
      check("t3_prod", resp_product, rr_prod[k % 4]);
      @(posedge clk);
      #1;
      check("t3_idle_valid", resp_valid, 0);
    end
    req_valid = 4'b0000;

    // 4: consumer back-pressure holds the response
    pulse_reset();
    set_op(0, 4'd7, 4'd8);
    req_valid  = 4'b0001;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 4'b0110;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", resp_valid, 1);
      check("t4_hold_prod", resp_product, 56);
      check("t4_hold_id", resp_id, 0);
      check("t4_hold_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_release_valid", resp_valid, 0);
    check("t4_next_grant", req_ready, 4'b0010);
    req_valid = 4'b0000;

    // 5a: reset during CALC
    @(negedge clk);
    set_op(0, 4'd5, 4'd5);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    check("t5a_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("t5a_busy", busy, 0);
    check("t5a_valid", resp_valid, 0);
    check("t5a_ready", req_ready, 0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("t5a_no_resp", resp_valid, 0);
    end
    req_valid = 4'b1111;
    #1;
    check("t5a_grant0", req_ready, 4'b0001);
    req_valid = 4'b0000;

    // 5b: reset during RESP
    @(negedge clk);
    set_op(2, 4'd3, 4'd4);
    req_valid = 4'b0100;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    check("t5b_resp_before", resp_valid, 1);
    check("t5b_prod_before", resp_product, 12);
    rst = 1'b1;
    #1;
    check("t5b_valid", resp_valid, 0);
    check("t5b_prod", resp_product, 0);
    check("t5b_id", resp_id, 0);
    check("t5b_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("t5b_no_resp", resp_valid, 0);
    end
    req_valid = 4'b1111;
    #1;
    check("t5b_grant0", req_ready, 4'b0001);
    req_valid = 4'b0000;

    // 6: pointer at 2 with requesters 1 and 3 -> 3 first, then 1, pointer back to 2
    do_single("t6_setup", 1, 4'd2, 4'd3, 8'd6);
    @(negedge clk);
    set_op(1, 4'd4, 4'd4);
    set_op(3, 4'd5, 4'd6);
    req_valid = 4'b1010;
    #1;
    check("t6_grant3", req_ready, 4'b1000);
    @(posedge clk);
    @(posedge clk); #1;
    check("t6_id3", resp_id, 3);
    check("t6_prod3", resp_product, 30);
    @(posedge clk); #1;
    check("t6_grant1", req_ready, 4'b0010);
    @(posedge clk);
    @(posedge clk); #1;
    check("t6_id1", resp_id, 1);
    check("t6_prod1", resp_product, 16);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    #1;
    check("t6_ptr2", req_ready, 4'b0100);
    req_valid = 4'b0000;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
